vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640: number of active pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch length, in clocks.
REQ-003 Parameter H_SYNC, default 96: horizontal sync pulse width, in clocks.
REQ-004 Parameter H_BACK, default 48: horizontal back porch length, in clocks.
REQ-005 Parameter V_VISIBLE, default 480: number of active lines per frame.
REQ-006 Parameter V_FRONT, default 10: vertical front porch length, in lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync pulse width, in lines.
REQ-008 Parameter V_BACK, default 33: vertical back porch length, in lines.
REQ-009 Ports SHALL be, in order (one clock; reset is asynchronous and active-high):
- vga_clk  input  1  pixel clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- hs  output  1  horizontal sync, active low.
- vs  output  1  vertical sync, active low.
- blank  output  1  1 = active display region (pixel may be drawn); 0 = porch/sync.
- sync  output  1  composite sync for the DAC; constant 0.
- DrawX  output  10  current horizontal pixel coordinate (horizontal counter).
- DrawY  output  10  current line coordinate (vertical counter).
- frame_start  output  1  one-clock pulse at DrawX=0, DrawY=0.
- line_end  output  1  one-clock pulse at DrawX=H_TOTAL-1.
- frame_count  output  8  number of completed frames since reset, mod 256.

Function
REQ-010 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 at defaults); V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525 at defaults).
REQ-011 DrawX SHALL increment by 1 each clock and wrap from H_TOTAL-1 to 0.
REQ-012 DrawY SHALL increment by 1 only on the clock where DrawX wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same clock.
REQ-013 hs SHALL be 0 exactly when H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751 at defaults), and 1 otherwise.
REQ-014 vs SHALL be 0 exactly when V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491 at defaults), and 1 otherwise.
REQ-015 blank SHALL be 1 exactly when DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-016 hs, vs, blank, frame_start and line_end SHALL be decoded from the current counter values with zero latency, aligned to the same cycle as DrawX/DrawY. A consumer that reads its ROM on the falling edge and registers pixels on the next rising edge therefore lags by one clock; this lag is the consumer's responsibility.
REQ-017 frame_start SHALL be 1 only when DrawX=0 and DrawY=0.
REQ-018 line_end SHALL be 1 only when DrawX=H_TOTAL-1, on every line including blanked lines.
REQ-019 frame_count SHALL increment by 1 on the clock where DrawX=H_TOTAL-1 and DrawY=V_TOTAL-1, and SHALL wrap from 255 to 0.
REQ-020 Counters SHALL be exactly 10 bits; parameter sets with H_TOTAL or V_TOTAL above 1024 are unsupported.
REQ-021 Coordinate comparisons SHALL be unsigned and made at full counter width, with no truncation.

Reset
REQ-022 While Reset=1: DrawX=0, DrawY=0, frame_count=0, independent of vga_clk.
REQ-023 Outputs during reset SHALL follow REQ-013..REQ-017 for counter state (0,0): hs=1, vs=1, blank=1, frame_start=1, line_end=0, sync=0.
REQ-024 Reset asserted mid-frame SHALL return the counters to 0 immediately and asynchronously; no partial line or frame is completed.
REQ-025 On the first rising edge after Reset deasserts, DrawX SHALL become 1.

Verification
REQ-026 Reset, then release and run 800 clocks -> DrawX steps 0..799 then returns to 0; DrawY goes 0->1 on that wrap; line_end=1 only at DrawX=799.
REQ-027 Run line 0 -> hs=0 for exactly 96 clocks at DrawX=656..751; blank=1 for DrawX 0..639 and 0 for 640..799.
REQ-028 Run one full frame (420000 clocks) -> vs=0 for exactly 1600 clocks, on lines 490..491; blank=0 on all of lines 480..524; frame_count goes 0->1 at the wrap; frame_start pulses once per frame.
REQ-029 Run 256 frames -> frame_count wraps from 255 to 0; frame_start pulse count = 256.
REQ-030 Assert Reset asynchronously at DrawX=300, DrawY=200, mid-clock -> DrawX=0 and DrawY=0 before the next rising edge; after release, the sequence restarts per REQ-025.
REQ-031 Instantiate with H_VISIBLE=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=1 -> H_TOTAL=14, V_TOTAL=7; hs low at DrawX 10..11; vs low on line 5.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with
// zero-latency sync, blanking and frame/line markers decoded from them.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       Reset,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       line_end,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // One bit wider than the counters so a boundary of exactly 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

    logic [10:0] x_wide;
    logic [10:0] y_wide;
    logic        last_line;

    assign x_wide = {1'b0, DrawX};
    assign y_wide = {1'b0, DrawY};

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        hs          = 1'b1;
        vs          = 1'b1;
        blank       = 1'b0;
        sync        = 1'b0;
        frame_start = 1'b0;
        line_end    = 1'b0;
        last_line   = 1'b0;

        if (x_wide >= H_SYNC_BEG && x_wide < H_SYNC_END) hs = 1'b0;
        if (y_wide >= V_SYNC_BEG && y_wide < V_SYNC_END) vs = 1'b0;
        if (x_wide < H_VIS_END && y_wide < V_VIS_END)    blank = 1'b1;
        if (DrawX == 10'd0 && DrawY == 10'd0)            frame_start = 1'b1;
        if (x_wide == H_LAST)                            line_end = 1'b1;
        if (y_wide == V_LAST)                            last_line = 1'b1;
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            frame_count <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values of the others.
            if (line_end) begin
                DrawX <= '0;
                if (last_line) begin
                    DrawY       <= '0;
                    frame_count <= frame_count + 8'd1;
                end else begin
                    DrawY <= DrawY + 10'd1;
                end
            end else begin
                DrawX <= DrawX + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default-timing instance for line-level
// behaviour and a tiny-timing instance for frame-level and wrap behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    logic rst_a, rst_b;

    logic       hs_a, vs_a, blank_a, sync_a, frame_start_a, line_end_a;
    logic [9:0] DrawX_a, DrawY_a;
    logic [7:0] frame_count_a;
    logic       hs_b, vs_b, blank_b, sync_b, frame_start_b, line_end_b;
    logic [9:0] DrawX_b, DrawY_b;
    logic [7:0] frame_count_b;

    vga_timing_gen dut_a (
        .vga_clk(clk), .Reset(rst_a), .hs(hs_a), .vs(vs_a), .blank(blank_a),
        .sync(sync_a), .DrawX(DrawX_a), .DrawY(DrawY_a),
        .frame_start(frame_start_a), .line_end(line_end_a), .frame_count(frame_count_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_b (
        .vga_clk(clk), .Reset(rst_b), .hs(hs_b), .vs(vs_b), .blank(blank_b),
        .sync(sync_b), .DrawX(DrawX_b), .DrawY(DrawY_b),
        .frame_start(frame_start_b), .line_end(line_end_b), .frame_count(frame_count_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: everything follows from the number of clocks since reset release.
    function automatic logic [33:0] model(input int t, input int hv, input int hf, input int hsy,
                                          input int hb, input int vv, input int vf, input int vsy,
                                          input int vb);
        int ht, vt, x, y, f;
        logic e_hs, e_vs, e_blank;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        x  = t % ht;
        y  = (t / ht) % vt;
        f  = (t / (ht * vt)) % 256;
        e_hs    = !(x >= hv + hf && x < hv + hf + hsy);
        e_vs    = !(y >= vv + vf && y < vv + vf + vsy);
        e_blank = (x < hv) && (y < vv);
        return {e_hs, e_vs, e_blank, 1'b0, 10'(x), 10'(y), (x == 0 && y == 0), (x == ht - 1), 8'(f)};
    endfunction

    int t_a, t_b;
    always @(posedge clk or posedge rst_a) if (rst_a) t_a <= 0; else t_a <= t_a + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) t_b <= 0; else t_b <= t_b + 1;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_a", {hs_a, vs_a, blank_a, sync_a, DrawX_a, DrawY_a, frame_start_a,
                              line_end_a, frame_count_a},
                  model(t_a, 640, 16, 96, 48, 480, 10, 2, 33));
            check("cycle_b", {hs_b, vs_b, blank_b, sync_b, DrawX_b, DrawY_b, frame_start_b,
                              line_end_b, frame_count_b},
                  model(t_b, 8, 2, 2, 2, 4, 1, 1, 1));
        end
    end

    task automatic run_a();
        int hs_low = 0, hs_first = -1, blank_cnt = 0, le_cnt = 0, le_pos = -1;
        for (int i = 0; i < 800; i++) begin
            if (!hs_a) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
            if (blank_a) blank_cnt++;
            if (line_end_a) begin
                le_cnt++;
                le_pos = i;
            end
            if (i == 1) check("a_first_edge_x", DrawX_a, 1);
            if (i == 799) check("a_x_799", DrawX_a, 799);
            @(posedge clk); #1;
        end
        check("a_wrap_x", DrawX_a, 0);
        check("a_wrap_y", DrawY_a, 1);
        check("a_hs_low_cnt", hs_low, 96);
        check("a_hs_first", hs_first, 656);
        check("a_blank_cnt", blank_cnt, 640);
        check("a_line_end_cnt", le_cnt, 1);
        check("a_line_end_pos", le_pos, 799);

        repeat (300) @(posedge clk);
        #1;
        check("a_pre_rst_x", DrawX_a, 300);
        check("a_pre_rst_y", DrawY_a, 1);
        #2 rst_a = 1'b1;
        #1;
        check("a_async_x", DrawX_a, 0);
        check("a_async_y", DrawY_a, 0);
        check("a_async_hs_fs", {hs_a, frame_start_a}, 2'b11);
        @(negedge clk); #1 rst_a = 1'b0;
        @(posedge clk); #1;
        check("a_restart_x", DrawX_a, 1);
        check("a_restart_y", DrawY_a, 0);
    endtask

    task automatic run_b();
        localparam int N = 98 * 256;
        int fs_cnt = 0, vs_low = 0, vs_bad_line = 0, late_blank = 0, hs_bad = 0;
        bit found = 0;
        for (int i = 0; i <= N; i++) begin
            if (i < N && frame_start_b) fs_cnt++;
            if (i < 98) begin
                if (!vs_b) begin
                    vs_low++;
                    if (i / 14 != 5) vs_bad_line++;
                end
                if (i / 14 >= 4 && blank_b) late_blank++;
                if (!hs_b && (i % 14 < 10 || i % 14 > 11)) hs_bad++;
            end
            if (i == 97)       check("b_fc_before_wrap", frame_count_b, 0);
            if (i == 98)       check("b_fc_after_wrap", frame_count_b, 1);
            if (i == 98 * 255) check("b_fc_255", frame_count_b, 255);
            if (i == N)        check("b_fc_wrap_0", frame_count_b, 0);
            if (i < N) begin
                @(posedge clk); #1;
            end
        end
        check("b_frame_start_cnt", fs_cnt, 256);
        check("b_vs_low_cnt", vs_low, 14);
        check("b_vs_wrong_line", vs_bad_line, 0);
        check("b_blank_in_vblank", late_blank, 0);
        check("b_hs_outside_10_11", hs_bad, 0);

        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (DrawX_b == 10'd5 && DrawY_b == 10'd3) found = 1;
        end
        check("b_reach_5_3", found, 1);
        #2 rst_b = 1'b1;
        #1;
        check("b_async_xy", {DrawX_b, DrawY_b, frame_count_b}, 28'd0);
        @(negedge clk); #1 rst_b = 1'b0;
        @(posedge clk); #1;
        check("b_restart_x", DrawX_b, 1);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        #12;
        cmp_en = 1'b1;
        check("rst_counters", {DrawX_a, DrawY_a, frame_count_a}, 28'd0);
        check("rst_outputs", {hs_a, vs_a, blank_a, frame_start_a, line_end_a, sync_a}, 6'b111100);
        @(negedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        fork
            run_a();
            run_b();
        join
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
